// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// regfile_wb_arbiter_if: issue/hold controls, two writeback requesters, register-file write port and busy scoreboard.
interface regfile_wb_arbiter_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;

  logic                     issue_valid;
  logic [ADDRESS_WIDTH-1:0] issue_rd;
  logic                     hold;

  logic                     req0_valid;
  logic [ADDRESS_WIDTH-1:0] req0_rd;
  logic [DATA_WIDTH-1:0]    req0_data;
  logic                     req0_ready;

  logic                     req1_valid;
  logic [ADDRESS_WIDTH-1:0] req1_rd;
  logic [DATA_WIDTH-1:0]    req1_data;
  logic                     req1_ready;

  logic                     RegWrite;
  logic [ADDRESS_WIDTH-1:0] WRITE_ADDRESS;
  logic [DATA_WIDTH-1:0]    WRITE_DATA;
  logic [NUM_REGS-1:0]      busy;

  modport master (
    output issue_valid, issue_rd, hold,
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready,
    input  RegWrite, WRITE_ADDRESS, WRITE_DATA, busy
  );

  modport slave (
    input  issue_valid, issue_rd, hold,
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready,
    output RegWrite, WRITE_ADDRESS, WRITE_DATA, busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// regfile_wb_arbiter: shares the register-file write port between ALU (req0) and LSU (req1), with a RAW busy scoreboard.
// Macro WB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise req1 has fixed priority.
module regfile_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  regfile_wb_arbiter_if.slave wb
);
  localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;

  logic                     grant0;
  logic                     grant1;
  logic                     transfer;
  logic [ADDRESS_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0]    sel_data;

  logic                     reg_write_q, reg_write_d;
  logic [ADDRESS_WIDTH-1:0] write_address_q, write_address_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
  logic [NUM_REGS-1:0]      busy_q, busy_d;

`ifdef WB_ROUND_ROBIN_EN
  // rr_ptr: 0 prefers req0, 1 prefers req1
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (!wb.hold) begin
      if (wb.req0_valid && wb.req1_valid) begin
        grant0 = ~rr_ptr_q;
        grant1 = rr_ptr_q;
      end else begin
        grant0 = wb.req0_valid;
        grant1 = wb.req1_valid;
      end
      if (grant0) begin
        rr_ptr_d = 1'b1;
      end else if (grant1) begin
        rr_ptr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    grant1 = !wb.hold && wb.req1_valid;
    grant0 = !wb.hold && wb.req0_valid && !wb.req1_valid;
  end
`endif

  assign transfer      = grant0 || grant1;
  assign sel_rd        = grant1 ? wb.req1_rd   : wb.req0_rd;
  assign sel_data      = grant1 ? wb.req1_data : wb.req0_data;
  assign wb.req0_ready = grant0;
  assign wb.req1_ready = grant1;

  always_comb begin
    reg_write_d     = transfer && (sel_rd != '0);
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    busy_d          = busy_q;
    if (transfer) begin
      write_address_d = sel_rd;
      write_data_d    = sel_data;
      busy_d[sel_rd]  = 1'b0;
    end
    // Issue is applied after the clear so a new producer of the same register stays outstanding
    if (wb.issue_valid) begin
      busy_d[wb.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      reg_write_q     <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      busy_q          <= '0;
    end else begin
      reg_write_q     <= reg_write_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      busy_q          <= busy_d;
    end
  end

  assign wb.RegWrite      = reg_write_q;
  assign wb.WRITE_ADDRESS = write_address_q;
  assign wb.WRITE_DATA    = write_data_q;
  assign wb.busy          = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// tb_regfile_wb_arbiter: directed and randomized checks of the writeback arbiter against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2 ** AW;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  regfile_wb_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

  regfile_wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .wb      (wb)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit          m_known;
  bit          m_busy [NR];
  bit          m_ptr;
  bit          last_g0, last_g1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR-1:0] busy_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    m_we    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_known = 1'b1;
    m_ptr   = 1'b0;
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
  endtask

  task automatic idle_inputs();
    wb.issue_valid = 1'b0; wb.issue_rd = '0; wb.hold = 1'b0;
    wb.req0_valid = 1'b0; wb.req0_rd = '0; wb.req0_data = '0;
    wb.req1_valid = 1'b0; wb.req1_rd = '0; wb.req1_data = '0;
  endtask

  // One clock: check readies mid-cycle, advance the model, check registered outputs after the edge
  task automatic step();
    bit g0, g1;
    logic [AW-1:0] rd;
    #2;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!wb.hold) begin
`ifdef WB_ROUND_ROBIN_EN
      if (wb.req0_valid && wb.req1_valid) begin
        if (m_ptr) g1 = 1'b1; else g0 = 1'b1;
      end else begin
        g0 = wb.req0_valid;
        g1 = wb.req1_valid;
      end
      if (g0) m_ptr = 1'b1;
      else if (g1) m_ptr = 1'b0;
`else
      if (wb.req1_valid) g1 = 1'b1;
      else if (wb.req0_valid) g0 = 1'b1;
`endif
    end
    check("req0_ready", 64'(wb.req0_ready), 64'(g0));
    check("req1_ready", 64'(wb.req1_ready), 64'(g1));
    m_we = 1'b0;
    if (g0 || g1) begin
      rd = g1 ? wb.req1_rd : wb.req0_rd;
      if (rd != '0) begin
        m_we       = 1'b1;
        m_addr     = rd;
        m_data     = g1 ? wb.req1_data : wb.req0_data;
        m_known    = 1'b1;
        m_busy[rd] = 1'b0;
      end else begin
        m_known = 1'b0;
      end
    end
    if (wb.issue_valid && wb.issue_rd != '0) m_busy[wb.issue_rd] = 1'b1;
    last_g0 = g0;
    last_g1 = g1;
    @(posedge clock);
    #1;
    check("RegWrite", 64'(wb.RegWrite), 64'(m_we));
    if (m_known) begin
      check("WRITE_ADDRESS", 64'(wb.WRITE_ADDRESS), 64'(m_addr));
      check("WRITE_DATA", 64'(wb.WRITE_DATA), 64'(m_data));
    end
    check("busy", 64'(wb.busy), 64'(busy_vec()));
  endtask

  initial begin
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("reset_RegWrite", 64'(wb.RegWrite), 64'd0);
    check("reset_addr", 64'(wb.WRITE_ADDRESS), 64'd0);
    check("reset_data", 64'(wb.WRITE_DATA), 64'd0);
    check("reset_busy", 64'(wb.busy), 64'd0);

    // Simultaneous requests straight after reset
    wb.req0_valid = 1'b1; wb.req0_rd = 5'd3; wb.req0_data = 32'h11;
    wb.req1_valid = 1'b1; wb.req1_rd = 5'd4; wb.req1_data = 32'h22;
    step();
`ifdef WB_ROUND_ROBIN_EN
    check("both_first", 64'(wb.WRITE_ADDRESS), 64'd3);
`else
    check("both_first", 64'(wb.WRITE_ADDRESS), 64'd4);
`endif
    if (last_g1) wb.req1_valid = 1'b0; else wb.req0_valid = 1'b0;
    step();
`ifdef WB_ROUND_ROBIN_EN
    check("both_second", 64'(wb.WRITE_ADDRESS), 64'd4);
`else
    check("both_second", 64'(wb.WRITE_ADDRESS), 64'd3);
`endif
    idle_inputs();
    step();

    // Single ALU write
    wb.req0_valid = 1'b1; wb.req0_rd = 5'd5; wb.req0_data = 32'hDEADBEEF;
    step();
    check("alu_we", 64'(wb.RegWrite), 64'd1);
    check("alu_addr", 64'(wb.WRITE_ADDRESS), 64'd5);
    check("alu_data", 64'(wb.WRITE_DATA), 64'hDEADBEEF);
    idle_inputs();

    // Scoreboard set, clear, and set-wins-over-clear
    wb.issue_valid = 1'b1; wb.issue_rd = 5'd7;
    step();
    check("busy7_set", 64'(wb.busy[7]), 64'd1);
    idle_inputs();
    wb.req1_valid = 1'b1; wb.req1_rd = 5'd7; wb.req1_data = 32'hA5A5_0007;
    step();
    check("busy7_clear", 64'(wb.busy[7]), 64'd0);
    check("busy7_we", 64'(wb.RegWrite), 64'd1);
    idle_inputs();
    wb.issue_valid = 1'b1; wb.issue_rd = 5'd7;
    step();
    wb.req1_valid = 1'b1; wb.req1_rd = 5'd7; wb.req1_data = 32'h77;
    step();
    check("busy7_setwins", 64'(wb.busy[7]), 64'd1);
    idle_inputs();

    // Register 0
    wb.issue_valid = 1'b1; wb.issue_rd = 5'd0;
    step();
    check("busy0", 64'(wb.busy[0]), 64'd0);
    idle_inputs();
    wb.req0_valid = 1'b1; wb.req0_rd = 5'd0; wb.req0_data = 32'hFFFFFFFF;
    step();
    check("r0_we", 64'(wb.RegWrite), 64'd0);
    idle_inputs();

    // hold with both valid, then release
    wb.hold = 1'b1;
    wb.req0_valid = 1'b1; wb.req0_rd = 5'd10; wb.req0_data = 32'h1010;
    wb.req1_valid = 1'b1; wb.req1_rd = 5'd11; wb.req1_data = 32'h1111;
    repeat (3) step();
    wb.hold = 1'b0;
    step();
    check("hold_resume_we", 64'(wb.RegWrite), 64'd1);
    idle_inputs();

    // Randomized traffic; requesters keep their request stable until granted
    for (int i = 0; i < 400; i++) begin
      if (!wb.req0_valid || last_g0) begin
        wb.req0_valid = 1'($urandom_range(0, 1));
        wb.req0_rd    = AW'($urandom);
        wb.req0_data  = $urandom;
      end
      if (!wb.req1_valid || last_g1) begin
        wb.req1_valid = 1'($urandom_range(0, 1));
        wb.req1_rd    = AW'($urandom);
        wb.req1_data  = $urandom;
      end
      wb.hold        = ($urandom_range(0, 7) == 0);
      wb.issue_valid = 1'($urandom_range(0, 1));
      wb.issue_rd    = AW'($urandom);
      step();
    end
    idle_inputs();

    // Reset in the middle of a transfer
    wb.issue_valid = 1'b1; wb.issue_rd = 5'd9;
    step();
    idle_inputs();
    wb.req0_valid = 1'b1; wb.req0_rd = 5'd12; wb.req0_data = 32'hC0FFEE;
    #2;
    check("midrst_ready", 64'(wb.req0_ready), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_we", 64'(wb.RegWrite), 64'd0);
    check("midrst_busy", 64'(wb.busy), 64'd0);
    @(posedge clock);
    #1;
    check("midrst_we_edge", 64'(wb.RegWrite), 64'd0);
    check("midrst_addr", 64'(wb.WRITE_ADDRESS), 64'd0);
    idle_inputs();
    model_reset();
    reset_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: req0 (ALU) and req1 (load/store unit).
- Valid/ready handshake on each requester; registered write-port outputs drive RegWrite / WRITE_ADDRESS / WRITE_DATA of the register file.
- Keeps a per-register busy scoreboard: set at issue, cleared at writeback, so issue logic can stall on RAW hazards.

Parameters:
- ADDRESS_WIDTH, 5, register index width; 2**ADDRESS_WIDTH registers.
- DATA_WIDTH, 32, writeback data width.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- issue_valid  input  1  an instruction with destination issue_rd issued this cycle.
- issue_rd  input  ADDRESS_WIDTH  destination register of the issued instruction.
- hold  input  1  pipeline control; blocks all grants while high.
- req0_valid  input  1  ALU writeback request.
- req0_rd  input  ADDRESS_WIDTH  ALU destination register.
- req0_data  input  DATA_WIDTH  ALU result.
- req0_ready  output  1  ALU request granted this cycle (combinational).
- req1_valid  input  1  LSU writeback request.
- req1_rd  input  ADDRESS_WIDTH  LSU destination register.
- req1_data  input  DATA_WIDTH  load data.
- req1_ready  output  1  LSU request granted this cycle (combinational).
- RegWrite  output  1  register-file write enable (registered).
- WRITE_ADDRESS  output  ADDRESS_WIDTH  register-file write index (registered).
- WRITE_DATA  output  DATA_WIDTH  register-file write data (registered).
- busy  output  2**ADDRESS_WIDTH  scoreboard; bit i = write to register i outstanding.

Behaviour:
- Reset (reset_n low, asynchronous): RegWrite=0, WRITE_ADDRESS=0, WRITE_DATA=0, busy=all 0, round-robin pointer=req0.
- Reset asserted mid-operation discards any pending write and all busy bits.
- Handshake: a transfer occurs when reqN_valid && reqN_ready.
  - reqN_ready is never high unless reqN_valid is high.
  - At most one ready is high per cycle.
  - hold=1 forces both readies to 0.
- Requesters hold valid/rd/data stable until ready. The arbiter places no constraint on requester behaviour after a transfer.
- Default priority is fixed: req1 (LSU) wins when both are valid. req0 waits.
- Latency: a transfer in cycle T produces RegWrite=1 in cycle T+1, with WRITE_ADDRESS/WRITE_DATA equal to the granted rd/data. The register file commits at the edge ending T+1.
- No transfer in cycle T: RegWrite=0 in T+1. WRITE_ADDRESS/WRITE_DATA hold their previous values.
- Full throughput: one write per cycle. Back-to-back grants to the same or different requesters are allowed.
- rd=0:
  - The transfer is still accepted (ready asserted).
  - RegWrite stays 0 in T+1.
  - busy bit 0 is never set.
- Scoreboard set: issue_valid with issue_rd!=0 sets busy[issue_rd] at the clock edge.
- Scoreboard clear: a transfer with rd=k clears busy[k] at the same edge that loads the output register, so busy[k]=0 in the cycle RegWrite=1.
- Same register set and cleared at one edge (issue_rd==granted rd): set wins and busy stays 1 (the new producer is outstanding).
- A writeback to a register whose busy bit is already 0 is legal: the write happens and busy stays 0.
- busy[0] is constant 0.

Optional Feature:
- Macro: WB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A 1-bit pointer names the preferred requester.
  - When both are valid, the preferred requester is granted.
  - After any grant, the pointer moves to the non-granted requester.
  - When only one is valid, that one is granted and the pointer moves to the other.
  - hold freezes the pointer.
- Undefined: fixed priority, req1 over req0. No pointer state exists.

Test Plan:
- Reset release, idle: busy=0, RegWrite=0.
  - req0 rd=5 data=0xDEADBEEF -> req0_ready=1 in T; RegWrite=1, WRITE_ADDRESS=5, WRITE_DATA=0xDEADBEEF in T+1.
- Simultaneous requests, req0 rd=3 data=0x11 and req1 rd=4 data=0x22, for 2 cycles:
  - Fixed priority: outputs rd4 then rd3.
  - With WB_ROUND_ROBIN_EN after reset: rd3 then rd4.
- Scoreboard:
  - issue_valid rd=7 -> busy[7]=1 next cycle.
  - req1 rd=7 transfer -> busy[7]=0 in the same cycle RegWrite=1.
  - issue rd=7 in the same cycle as the transfer -> busy[7] stays 1.
- Register 0:
  - issue rd=0 -> busy unchanged.
  - req0 rd=0 data=0xFFFFFFFF -> req0_ready=1, RegWrite stays 0.
- hold=1 with both valid for 3 cycles -> no readies, RegWrite=0; grants resume the cycle hold drops.
- Reset mid-operation: transfer in cycle T, reset_n low before the T+1 edge -> RegWrite=0 and busy=0 immediately, no write committed.
